// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction fetch sequencer. Drives a 1-cycle synchronous
//               imem, buffers returned words in a small queue and hands them
//               to decode over valid/ready; handles redirect, start and fault.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          NUM_INSTR = 1024,
  parameter int          QDEPTH    = 2
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        fault
);

  localparam int                 c_cnt_w     = $clog2(QDEPTH + 1);
  localparam int                 c_ptr_w     = $clog2(QDEPTH);
  localparam logic [c_cnt_w-1:0] c_qdepth    = c_cnt_w'(QDEPTH);
  localparam logic [c_ptr_w-1:0] c_last      = c_ptr_w'(QDEPTH - 1);
  localparam logic [31:0]        c_num_instr = 32'(NUM_INSTR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [31:0]         r_fetch_pc;
  logic                r_inflight;
  logic [31:0]         r_inflight_pc;
  logic                r_fault;
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_cnt_w-1:0]  r_count;
  logic [31:0]         r_q_instr [QDEPTH];
  logic [31:0]         r_q_pc    [QDEPTH];

  logic                w_bad;
  logic                w_pop;
  logic                w_issue;
  logic [c_cnt_w-1:0]  w_count_next;

  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
    return (p == c_last) ? '0 : p + c_ptr_w'(1);
  endfunction

  assign w_bad = (r_state == S_RUN) &&
                 ((r_fetch_pc[1:0] != 2'b00) || ({2'b00, r_fetch_pc[31:2]} >= c_num_instr));
  assign w_pop = instr_valid & instr_ready;
  // Credit check counts the word already in flight, so the queue never overflows.
  assign w_count_next = r_count + c_cnt_w'(r_inflight) - c_cnt_w'(w_pop);
  assign w_issue = (r_state == S_RUN) && !w_bad && !redirect_valid && (w_count_next < c_qdepth);

  assign imem_pc     = r_fetch_pc;
  assign fault       = r_fault;
  assign instr_valid = (r_count != '0);
  assign instr_out   = instr_valid ? r_q_instr[r_rd_ptr] : 32'h0;
  assign pc_out      = instr_valid ? r_q_pc[r_rd_ptr]    : 32'h0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start && !redirect_valid) w_state_next = S_RUN;
      S_RUN:   if (!redirect_valid && w_bad) w_state_next = S_HALT;
      S_HALT:  if (redirect_valid) w_state_next = S_RUN;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= 32'h0;
      r_fault       <= 1'b0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc;
      r_inflight <= 1'b0;
      r_fault    <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + 32'd4;
      end
      if (w_bad) r_fault <= 1'b1;
      if (r_inflight) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= w_count_next;
    end
  end

  // Queue storage needs no reset: reads are masked by instr_valid.
  always_ff @(posedge clk) begin
    if (r_inflight && !redirect_valid) begin
      r_q_instr[r_wr_ptr] <= imem_instr;
      r_q_pc[r_wr_ptr]    <= r_inflight_pc;
    end
  end

endmodule
`default_nettype wire
